// File: rtl/ringcounter_pkg.sv
// Shared encodings for the ring counter family: run modes and bounce direction.
package ringcounter_pkg;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/ring_counter_mode_div_clk_en_div.sv
// Clock-enable prescaler: emits a one-cycle tick every DIV enabled mclk cycles.
module clk_en_div #(
  parameter int DIV = 25_000_000
) (
  input  logic mclk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // With DIV=1 the count never leaves zero, so tick simply follows en.
  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ring_counter_mode_div.sv
// One-hot ring counter with LEFT/RIGHT/BOUNCE/HOLD modes, load, and illegal-state recovery.
module ring_counter_mode_div
  import ringcounter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 25_000_000
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             step,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

  logic             tick;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             one_hot;

  clk_en_div #(.DIV(DIV)) u_div (
    .mclk (mclk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign one_hot = (cnt_q != '0) && ((cnt_q & (cnt_q - ONE)) == '0);

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = load_val;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (!one_hot) begin
        // Recovery outranks the mode action; HOLD deliberately leaves a bad value alone.
        case (mode)
          MODE_LEFT, MODE_BOUNCE: begin
            cnt_d  = ONE;
            dir_d  = DIR_UP;
            step_d = 1'b1;
          end
          MODE_RIGHT: begin
            cnt_d  = MSB;
            step_d = 1'b1;
          end
          default: ;
        endcase
      end else begin
        case (mode)
          MODE_LEFT: begin
            step_d = 1'b1;
            wrap_d = (cnt_q == MSB);
            cnt_d  = (cnt_q == MSB) ? ONE : (cnt_q << 1);
          end
          MODE_RIGHT: begin
            step_d = 1'b1;
            wrap_d = (cnt_q == ONE);
            cnt_d  = (cnt_q == ONE) ? MSB : (cnt_q >> 1);
          end
          MODE_BOUNCE: begin
            step_d = 1'b1;
            if (dir_q == DIR_UP) begin
              if (cnt_q == MSB) begin
                cnt_d  = MSB >> 1;
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
              end else begin
                cnt_d = cnt_q << 1;
              end
            end else begin
              if (cnt_q == ONE) begin
                cnt_d  = ONE << 1;
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end else begin
                cnt_d = cnt_q >> 1;
              end
            end
          end
          default: ;
        endcase
      end
    end
    // Outside BOUNCE the direction is pinned so re-entering BOUNCE always heads up.
    if (mode != MODE_BOUNCE) begin
      dir_d = DIR_UP;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      cnt_q  <= ONE;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_mode_div.sv
// Randomised and directed checks of ring_counter_mode_div against a position-based reference model.
module tb_ring_counter_mode_div;

  localparam int W = 8;
  localparam int D = 4;

  logic         mclk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] cnt;
  logic         step;
  logic         wrap;

  int errors = 0;
  int checks = 0;

  // Reference model state: value, prescaler phase, bounce heading, last pulses.
  logic [W-1:0] m_cnt;
  int           m_phase;
  bit           m_up;
  bit           m_step;
  bit           m_wrap;

  ring_counter_mode_div #(.WIDTH(W), .DIV(D)) dut (
    .mclk     (mclk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .step     (step),
    .wrap     (wrap)
  );

  always #5 mclk = ~mclk;

  task automatic model_update();
    bit ticked;
    int pos;
    if (!rst) begin
      m_cnt = 1; m_phase = 0; m_up = 1; m_step = 0; m_wrap = 0;
      return;
    end
    ticked = en && (m_phase == D - 1);
    if (load) m_phase = 0;
    else if (en) m_phase = (m_phase + 1) % D;
    m_step = 0; m_wrap = 0;
    if (load) begin
      m_cnt = load_val; m_up = 1;
    end else if (ticked) begin
      if ($countones(m_cnt) != 1) begin
        if (mode == 2'd0 || mode == 2'd2) begin m_cnt = 1; m_up = 1; m_step = 1; end
        else if (mode == 2'd1) begin m_cnt = 8'h80; m_step = 1; end
      end else begin
        pos = 0;
        for (int i = 0; i < W; i++) if (m_cnt[i]) pos = i;
        case (mode)
          2'd0: begin m_wrap = (pos == W - 1); pos = (pos + 1) % W; end
          2'd1: begin m_wrap = (pos == 0); pos = (pos + W - 1) % W; end
          2'd2: begin
            if (m_up && pos == W - 1) begin pos = W - 2; m_up = 0; m_wrap = 1; end
            else if (!m_up && pos == 0) begin pos = 1; m_up = 1; m_wrap = 1; end
            else pos = m_up ? pos + 1 : pos - 1;
          end
          default: ;
        endcase
        m_step = (mode != 2'd3);
        m_cnt = 8'(1 << pos);
      end
    end
    if (mode != 2'd2) m_up = 1;
  endtask

  task automatic run_cycle();
    @(posedge mclk);
    model_update();
    #1;
    if (m_step) $display("step cnt=%h wrap=%b mode=%0d", m_cnt, m_wrap, mode);
  endtask

  task automatic apply_reset();
    rst = 1'b0; load = 1'b0;
    run_cycle(); run_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; mode = 2'd0;
    apply_reset();
    checks++;
    if (cnt !== 8'h01 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset cnt=%h step=%b wrap=%b expected cnt=01 step=0 wrap=0", cnt, step, wrap);
    end
  endtask

  task automatic test_mode_run(input logic [1:0] md, input int cycles, input int exp_steps, input int exp_wraps);
    int steps_seen = 0;
    int wraps_seen = 0;
    mode = md; en = 1'b1;
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      run_cycle();
      steps_seen += int'(step);
      wraps_seen += int'(wrap);
      checks++;
      if ({cnt, step, wrap} !== {m_cnt, m_step, m_wrap}) begin
        errors++;
        $display("FAIL run mode=%0d cyc=%0d cnt=%h step=%b wrap=%b expected cnt=%h step=%b wrap=%b",
                 md, c, cnt, step, wrap, m_cnt, m_step, m_wrap);
      end
    end
    checks++;
    if (steps_seen != exp_steps || wraps_seen != exp_wraps) begin
      errors++;
      $display("FAIL pulse_count mode=%0d steps=%0d wraps=%0d expected steps=%0d wraps=%0d",
               md, steps_seen, wraps_seen, exp_steps, exp_wraps);
    end
  endtask

  task automatic test_illegal(input logic [1:0] md, input logic [W-1:0] val, input logic [W-1:0] exp_rec);
    mode = md; en = 1'b1;
    load = 1'b1; load_val = val;
    run_cycle();
    load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (cnt !== val || step !== 1'b0) begin
        errors++;
        $display("FAIL illegal_hold val=%h cyc=%0d cnt=%h step=%b expected cnt=%h step=0", val, c, cnt, step, val);
      end
      run_cycle();
    end
    checks++;
    if (cnt !== exp_rec || step !== 1'b1 || wrap !== 1'b0 || cnt !== m_cnt) begin
      errors++;
      $display("FAIL illegal_recover val=%h cnt=%h step=%b wrap=%b expected cnt=%h step=1 wrap=0",
               val, cnt, step, wrap, exp_rec);
    end
  endtask

  task automatic test_en_hold();
    logic [W-1:0] held;
    mode = 2'd0; en = 1'b1;
    apply_reset();
    run_cycle(); run_cycle();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      checks++;
      if (cnt !== 8'h01 || step !== 1'b0 || {cnt, step, wrap} !== {m_cnt, m_step, m_wrap}) begin
        errors++;
        $display("FAIL en_freeze cyc=%0d cnt=%h step=%b expected cnt=01 step=0", c, cnt, step);
      end
    end
    en = 1'b1;
    run_cycle();
    checks++;
    if (cnt !== 8'h01) begin
      errors++;
      $display("FAIL en_resume_early cnt=%h expected 01", cnt);
    end
    run_cycle();
    checks++;
    if (cnt !== 8'h02 || step !== 1'b1) begin
      errors++;
      $display("FAIL en_resume cnt=%h step=%b expected cnt=02 step=1", cnt, step);
    end
    mode = 2'd3;
    held = cnt;
    for (int c = 0; c < 3 * D; c++) begin
      run_cycle();
      checks++;
      if (cnt !== held || step !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc=%0d cnt=%h step=%b wrap=%b expected cnt=%h step=0 wrap=0", c, cnt, step, wrap, held);
      end
    end
  endtask

  task automatic test_collision();
    int guard = 0;
    mode = 2'd0; en = 1'b1;
    apply_reset();
    run_cycle(); run_cycle();
    while (m_phase != D - 1 && guard < 2 * D) begin run_cycle(); guard++; end
    rst = 1'b0;
    run_cycle();
    rst = 1'b1;
    checks++;
    if (cnt !== 8'h01 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_at_tick cnt=%h step=%b wrap=%b expected cnt=01 step=0 wrap=0", cnt, step, wrap);
    end
    guard = 0;
    run_cycle();
    while (m_phase != D - 1 && guard < 2 * D) begin run_cycle(); guard++; end
    load = 1'b1; load_val = 8'h3c;
    run_cycle();
    load = 1'b0;
    checks++;
    if (cnt !== 8'h3c || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_vs_tick cnt=%h step=%b wrap=%b expected cnt=3c step=0 wrap=0", cnt, step, wrap);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      load = ($urandom_range(0, 24) == 0);
      load_val = ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      rst = ($urandom_range(0, 99) != 0);
      run_cycle();
      checks++;
      if ({cnt, step, wrap} !== {m_cnt, m_step, m_wrap}) begin
        errors++;
        $display("FAIL random cyc=%0d cnt=%h step=%b wrap=%b expected cnt=%h step=%b wrap=%b",
                 c, cnt, step, wrap, m_cnt, m_step, m_wrap);
      end
    end
    rst = 1'b1; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode_run(2'd0, 8 * D, 8, 1);
    test_mode_run(2'd1, 8 * D, 8, 1);
    test_mode_run(2'd2, 15 * D, 15, 2);
    test_illegal(2'd0, 8'h00, 8'h01);
    test_illegal(2'd1, 8'h05, 8'h80);
    test_illegal(2'd2, 8'hc0, 8'h01);
    test_en_hold();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
